cmd_saver: RTL and testbench

// Encoder side of the TRS-80 /CMD loader format: reads a memory range via a

---
 rtl/cmd_saver.sv | 219 +++++++++++++++++++++
 tb/tb_cmd_saver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_saver.sv
// rtl/cmd_saver.sv - TRS-80 /CMD encoder: streams a RAM range as load blocks plus a transfer block
module cmd_saver #(
  parameter int ADDR    = 16,
  parameter int MEM_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [ADDR-1:0] start_addr,
  input  logic [ADDR-1:0] end_addr,
  input  logic [ADDR-1:0] exec_addr,
  output logic            mem_rd,
  output logic [ADDR-1:0] mem_addr,
  input  logic [7:0]      mem_data,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_TYPE,
    S_HDR_LEN,
    S_HDR_LSB,
    S_HDR_MSB,
    S_RD_REQ,
    S_RD_WAIT,
    S_DATA,
    S_EXE_TYPE,
    S_EXE_LEN,
    S_EXE_LSB,
    S_EXE_MSB,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [ADDR:0]   r_rem;
  logic [ADDR-1:0] r_cur;
  logic [ADDR-1:0] r_exec;
  logic [8:0]      r_blk;
  logic [7:0]      r_lat;
  logic            r_mem_rd;
  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic [ADDR:0]   w_range;
  logic [8:0]      w_blk_n;
  logic [7:0]      w_len;
  logic            w_last_in_blk;
  logic            w_last_byte;

  assign w_accept      = r_out_valid & out_ready;
  assign w_range       = {1'b0, end_addr} - {1'b0, start_addr} + (ADDR+1)'(1);
  assign w_last_in_blk = (r_blk == 9'd1);
  assign w_last_byte   = (r_rem == (ADDR+1)'(1));

  // A 255-byte block would need length byte 0x01, which the loader reads
  // differently, so a 255 remainder is split as 128 + 127.
  always_comb begin
    w_blk_n = r_rem[8:0];
    if (r_rem == (ADDR+1)'(255)) begin
      w_blk_n = 9'd128;
    end else if (r_rem >= (ADDR+1)'(256)) begin
      w_blk_n = 9'd256;
    end
  end

  assign w_len = w_blk_n[7:0] + 8'd2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_cur       <= '0;
      r_exec      <= '0;
      r_blk       <= '0;
      r_lat       <= '0;
      r_mem_rd    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (end_addr < start_addr) begin
                r_error <= 1'b1;
              end else begin
                r_rem       <= w_range;
                r_cur       <= start_addr;
                r_exec      <= exec_addr;
                r_busy      <= 1'b1;
                r_out_valid <= 1'b1;
                r_out_data  <= 8'h01;
                r_state     <= S_HDR_TYPE;
              end
            end
          end
          S_HDR_TYPE: begin
            if (w_accept) begin
              r_out_data <= w_len;
              r_blk      <= w_blk_n;
              r_state    <= S_HDR_LEN;
            end
          end
          S_HDR_LEN: begin
            if (w_accept) begin
              r_out_data <= r_cur[7:0];
              r_state    <= S_HDR_LSB;
            end
          end
          S_HDR_LSB: begin
            if (w_accept) begin
              r_out_data <= r_cur[15:8];
              r_state    <= S_HDR_MSB;
            end
          end
          S_HDR_MSB: begin
            if (w_accept) begin
              r_out_valid <= 1'b0;
              r_mem_rd    <= 1'b1;
              r_state     <= S_RD_REQ;
            end
          end
          S_RD_REQ: begin
            r_lat   <= 8'd1;
            r_state <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (r_lat == 8'(MEM_LAT)) begin
              r_out_data  <= mem_data;
              r_out_valid <= 1'b1;
              r_state     <= S_DATA;
            end else begin
              r_lat <= r_lat + 8'd1;
            end
          end
          S_DATA: begin
            if (w_accept) begin
              r_cur <= r_cur + ADDR'(1);
              r_rem <= r_rem - (ADDR+1)'(1);
              r_blk <= r_blk - 9'd1;
              if (!w_last_in_blk) begin
                r_out_valid <= 1'b0;
                r_mem_rd    <= 1'b1;
                r_state     <= S_RD_REQ;
              end else if (!w_last_byte) begin
                r_out_data <= 8'h01;
                r_state    <= S_HDR_TYPE;
              end else begin
                r_out_data <= 8'h02;
                r_state    <= S_EXE_TYPE;
              end
            end
          end
          S_EXE_TYPE: begin
            if (w_accept) begin
              r_out_data <= 8'h02;
              r_state    <= S_EXE_LEN;
            end
          end
          S_EXE_LEN: begin
            if (w_accept) begin
              r_out_data <= r_exec[7:0];
              r_state    <= S_EXE_LSB;
            end
          end
          S_EXE_LSB: begin
            if (w_accept) begin
              r_out_data <= r_exec[15:8];
              r_state    <= S_EXE_MSB;
            end
          end
          S_EXE_MSB: begin
            if (w_accept) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_cur;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_cmd_saver.sv
// tb/tb_cmd_saver.sv - randomized scoreboard bench for cmd_saver
module tb_cmd_saver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [15:0] exec_addr = '0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  cmd_saver #(.ADDR(16), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] exp_q [$];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, rd_cnt = 0, acc_cnt = 0, valid_cnt = 0, busy_cnt = 0;
  int ready_mode = 0;
  bit hold_pend = 0;
  logic [7:0] hold_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Single-cycle read latency memory
  always @(posedge clock) if (mem_rd) mem_data <= mem[mem_addr];

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("extra_byte", int'(out_data), -1);
        else chk("stream_byte", int'(out_data), int'(exp_q.pop_front()));
      end
      if (hold_pend && out_valid) chk("hold_stable", int'(out_data), int'(hold_data));
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (mem_rd) rd_cnt++;
      if (out_valid) valid_cnt++;
      if (busy) busy_cnt++;
    end else begin
      hold_pend = 0;
    end
  end

  // Reference: a /CMD file is load blocks of at most 256 bytes (255 left -> 128+127)
  task automatic build_expected(input int s, input int e, input int x);
    int rem, cur, n;
    rem = e - s + 1;
    cur = s;
    while (rem > 0) begin
      n = (rem == 255) ? 128 : ((rem > 256) ? 256 : rem);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'((n + 2) % 256));
      exp_q.push_back(8'(cur % 256));
      exp_q.push_back(8'(cur / 256));
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(mem[cur]);
        cur = (cur + 1) % 65536;
      end
      rem -= n;
    end
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'(x % 256));
    exp_q.push_back(8'(x / 256));
  endtask

  task automatic pulse_start(input int s, input int e, input int x, input bit with_abort);
    @(posedge clock); #1;
    start_addr = 16'(s);
    end_addr   = 16'(e);
    exec_addr  = 16'(x);
    start      = 1'b1;
    abort      = with_abort;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_txn(input string tag, input int s, input int e, input int x,
                         input int mode, input bit extra_start);
    int waited;
    build_expected(s, e, x);
    done_cnt = 0;
    rd_cnt = 0;
    ready_mode = mode;
    pulse_start(s, e, x, 1'b0);
    if (extra_start) begin
      repeat (3) @(posedge clock);
      #1;
      start_addr = 16'h1234;
      end_addr   = 16'h1300;
      start      = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    waited = 0;
    while (done_cnt == 0 && waited < 20000) begin
      @(negedge clock);
      waited++;
    end
    chk({tag, "_timeout"}, int'(waited < 20000), 1);
    repeat (3) @(negedge clock);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_rd_count"}, rd_cnt, e - s + 1);
    chk({tag, "_busy_after"}, int'(busy), 0);
    exp_q.delete();
    ready_mode = 0;
  endtask

  initial begin
    int len, s, waited;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_error", int'({done, error}), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);

    run_txn("t1_small", 16'h5200, 16'h5203, 16'h5200, 0, 1'b0);
    run_txn("t2_512", 16'h4000, 16'h41FF, 16'h4000, 0, 1'b0);
    run_txn("t3_255", 16'h6000, 16'h60FE, 16'h6000, 0, 1'b0);
    run_txn("t3_257", 16'h7000, 16'h7100, 16'h7010, 1, 1'b0);
    run_txn("t_wrap", 16'hFF80, 16'hFFFF, 16'h8000, 1, 1'b0);
    chk("wrap_mem_addr", int'(mem_addr), 0);
    for (int k = 0; k < 5; k++) begin
      len = $urandom_range(1, 600);
      s = $urandom_range(0, 65535 - len);
      run_txn("t4_rand", s, s + len - 1, $urandom_range(0, 65535), 1, 1'b1);
    end

    // Inverted range
    err_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    pulse_start(16'h3001, 16'h3000, 16'h3000, 1'b0);
    repeat (4) @(negedge clock);
    chk("t5_error_pulse", err_cnt, 1);
    chk("t5_no_valid", valid_cnt, 0);
    chk("t5_no_busy", busy_cnt, 0);

    // Start with simultaneous abort stays idle
    valid_cnt = 0; busy_cnt = 0;
    pulse_start(16'h5000, 16'h5010, 16'h5000, 1'b1);
    repeat (4) @(negedge clock);
    chk("start_abort_busy", busy_cnt, 0);
    chk("start_abort_valid", valid_cnt, 0);

    // Abort while the second data byte is presented
    build_expected(16'h5200, 16'h520F, 16'h5200);
    acc_cnt = 0; done_cnt = 0; ready_mode = 0;
    pulse_start(16'h5200, 16'h520F, 16'h5200, 1'b0);
    waited = 0;
    while (acc_cnt < 5 && waited < 200) begin @(negedge clock); waited++; end
    chk("t6_first_bytes", int'(acc_cnt >= 5), 1);
    ready_mode = 2;
    @(negedge clock);
    waited = 0;
    while (!out_valid && waited < 50) begin @(negedge clock); waited++; end
    chk("t6_second_data_valid", int'(out_valid), 1);
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    chk("t6_abort_valid", int'(out_valid), 0);
    chk("t6_abort_busy", int'(busy), 0);
    chk("t6_abort_mem_rd", int'(mem_rd), 0);
    exp_q.delete();
    repeat (5) @(negedge clock);
    chk("t6_abort_no_done", done_cnt, 0);
    chk("t6_abort_accepted", acc_cnt, 5);

    // Reset mid-stream
    build_expected(16'h4000, 16'h40FF, 16'h4000);
    acc_cnt = 0; done_cnt = 0; ready_mode = 1;
    pulse_start(16'h4000, 16'h40FF, 16'h4000, 1'b0);
    waited = 0;
    while (acc_cnt < 10 && waited < 500) begin @(negedge clock); waited++; end
    chk("t6_reset_progress", int'(acc_cnt >= 10), 1);
    @(posedge clock); #1 reset = 1'b1;
    #2;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_strobes", int'({mem_rd, done, error}), 0);
    chk("t6_rst_mem_addr", int'(mem_addr), 0);
    exp_q.delete();
    ready_mode = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("t6_rst_no_done", done_cnt, 0);

    run_txn("t7_recover", 16'h5200, 16'h5203, 16'h5200, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
